modulation_segment_packer: RTL and testbench
============================================

# modulation_segment_packer

Downstream consumer of the per-segment if/else modulation selectors. Each cycle it may accept one 32-bit combined segment word, tags it with its position in a frame of `SEGS_PER_FRAME` segments, and buffers it in a first-word-fall-through FIFO. The FIFO drains over a valid/ready stream. The block also produces a per-frame modular checksum and a sticky overflow flag for segments dropped while the FIFO is full.

## Interface
Parameters:
- `WIDTH`, 32: segment word width.
- `DEPTH`, 8: FIFO entries; power of 2, at least 2.
- `SEGS_PER_FRAME`, 4: segments per frame; at least 1.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `seg_valid` in 1: `segment_combine` is presented this cycle.
- `segment_combine` in `WIDTH`: combined segment word from the upstream selector.
- `out_ready` in 1: downstream accepts `out_data` this cycle.
- `clear_overflow` in 1: clears `overflow`.
- `out_valid` out 1: FIFO head is valid.
- `out_data` out `WIDTH`: FIFO head word.
- `out_last` out 1: FIFO head is the final segment of its frame.
- `frame_sum` out `WIDTH`: checksum of the last completed frame.
- `frame_sum_valid` out 1: one-cycle pulse when `frame_sum` updates.
- `fifo_count` out `$clog2(DEPTH)+1`: occupied entries.
- `overflow` out 1: sticky; set when a segment is dropped.

## Operation
- **Storage.** Entries are `{last, data}`. Write pointer and read pointer are `$clog2(DEPTH)` bits and wrap naturally. `count` is tracked separately.
  - full = (`count == DEPTH`); empty = (`count == 0`).
  - Both are evaluated on the registered `count` at the start of the cycle.
- **Write.** A write is accepted when `seg_valid` is high and the FIFO is not full. On an accepted write:
  - `last` is set when `seg_idx == SEGS_PER_FRAME-1`.
  - `seg_idx` advances, wrapping to 0 after the last segment.
  - `acc` accumulates the data word, sum mod 2^`WIDTH`.
- **Frame close.** On an accepted write with `last` set:
  - `frame_sum` <= `acc` + data.
  - `frame_sum_valid` pulses.
  - `acc` <= 0.
- **Drop.** When `seg_valid` is high and the FIFO is full:
  - The word is discarded and `overflow` is set.
  - `seg_idx`, `acc` and `frame_sum` are unchanged, so the next accepted word takes the dropped word's frame position.
- **Read.** `out_valid` = not empty. `out_data` and `out_last` show the head entry. A pop occurs when `out_valid` and `out_ready` are both high; `out_ready` is ignored when empty.
- **Simultaneous write and pop.**
  - Not full: both occur and `count` is unchanged.
  - Full: the write is rejected (drop) and the pop occurs. Acceptance never depends on the same-cycle pop.
- **Overflow flag.** `clear_overflow` clears `overflow`. If a drop occurs in the same cycle, set wins.
- **Reset.** Clears pointers, `count`, `seg_idx` and `acc`. Output values during reset:
  - `out_valid` = 0, `out_data` = 0, `out_last` = 0.
  - `frame_sum` = 0, `frame_sum_valid` = 0.
  - `fifo_count` = 0, `overflow` = 0.
  - Reset mid-frame discards the partial frame and all buffered words. Memory contents need no reset, but `out_data` must read 0 while empty.

## Timing
- Write to output: a word accepted at edge N drives `out_valid`, `out_data` and `out_last` after edge N. With `out_ready` high it pops at edge N+1, giving 1-cycle latency.
- `frame_sum` and `frame_sum_valid` are registered and update at the same edge as the closing write. The pulse lasts exactly one cycle; back-to-back frames with `SEGS_PER_FRAME`=1 pulse every accepted cycle.
- `fifo_count` and `overflow` are registered and reflect the edge just taken.
- Sustained throughput is 1 word/cycle with `out_ready` held high. No combinational path from `seg_valid` to `out_valid`.

## Test plan
- **Reset and single frame.** Release reset; write 0x1, 0x2, 0x3, 0x4 on consecutive cycles with `out_ready`=0.
  - `fifo_count` reaches 4.
  - `out_last` is set only on the 4th entry.
  - `frame_sum`=0xA with a one-cycle pulse at the 4th write edge.
- **Full and drop.** Hold `out_ready`=0 and write 9 words with `DEPTH`=8.
  - 9th word is dropped; `overflow`=1; `fifo_count`=8.
  - Drain shows words 1–8 in order.
  - Next write takes frame position 0 (9 mod 4 would be wrong).
- **Simultaneous write and pop at full.** Fill 8, then `seg_valid`=1 and `out_ready`=1 together.
  - Pop occurs and the write is dropped; `fifo_count`=7; `overflow`=1.
- **Pass-through.** `out_ready`=1, continuous writes.
  - `out_valid` asserts the cycle after each write; `fifo_count` holds at 1; no drops.
- **Checksum wrap.** Frame of 0xFFFFFFFF, 0x2, 0x0, 0x0 -> `frame_sum`=0x1.
- **Asynchronous reset mid-frame.** Assert `reset` between edges after 2 writes.
  - Outputs go to 0 immediately.
  - The next frame of 0x5 ×4 gives `frame_sum`=0x14.
  - `clear_overflow` coincident with a drop leaves `overflow`=1.

Source files
------------

// File: rtl/modulation_segment_packer.sv
// Segment packer: tags each accepted segment with its frame position, buffers it in a
// first-word-fall-through FIFO, and produces a per-frame modular checksum plus a sticky drop flag.
module modulation_segment_packer #(
  parameter int WIDTH          = 32,
  parameter int DEPTH          = 8,
  parameter int SEGS_PER_FRAME = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     seg_valid,
  input  logic [WIDTH-1:0]         segment_combine,
  input  logic                     out_ready,
  input  logic                     clear_overflow,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_last,
  output logic [WIDTH-1:0]         frame_sum,
  output logic                     frame_sum_valid,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = (SEGS_PER_FRAME > 1) ? $clog2(SEGS_PER_FRAME) : 1;

  logic [WIDTH:0]     mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic [IW-1:0]      seg_idx;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH:0]     head;
  logic               full;
  logic               empty;
  logic               wr_en;
  logic               rd_en;
  logic               drop;
  logic               is_last;

  // Full/empty come from the registered count only, so acceptance never sees the same-cycle pop.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign wr_en   = seg_valid && !full;
  assign drop    = seg_valid && full;
  assign rd_en   = out_ready && !empty;
  assign is_last = (seg_idx == IW'(SEGS_PER_FRAME - 1));

  assign head       = mem[rd_ptr];
  assign out_valid  = !empty;
  assign out_data   = empty ? '0 : head[WIDTH-1:0];
  assign out_last   = empty ? 1'b0 : head[WIDTH];
  assign fifo_count = count;

  // Storage array carries no reset; empty masking keeps stale contents off the outputs.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {is_last, segment_combine};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      seg_idx         <= '0;
      acc             <= '0;
      frame_sum       <= '0;
      frame_sum_valid <= 1'b0;
      overflow        <= 1'b0;
    end else begin
      frame_sum_valid <= wr_en && is_last;
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (is_last) begin
          seg_idx   <= '0;
          acc       <= '0;
          frame_sum <= acc + segment_combine;
        end else begin
          seg_idx <= seg_idx + 1'b1;
          acc     <= acc + segment_combine;
        end
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_modulation_segment_packer.sv
// Directed bench for modulation_segment_packer: vector table plus hand-written corner sequences.
module tb_modulation_segment_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        seg_valid;
  logic [31:0] segment_combine;
  logic        out_ready;
  logic        clear_overflow;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic [31:0] frame_sum;
  logic        frame_sum_valid;
  logic [3:0]  fifo_count;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  modulation_segment_packer #(.WIDTH(32), .DEPTH(8), .SEGS_PER_FRAME(4)) dut (
    .clk(clk), .reset(reset), .seg_valid(seg_valid), .segment_combine(segment_combine),
    .out_ready(out_ready), .clear_overflow(clear_overflow), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .frame_sum(frame_sum),
    .frame_sum_valid(frame_sum_valid), .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sv;
    logic [31:0] d;
    logic        rdy;
    logic        clr;
    logic        e_vld;
    logic [31:0] e_data;
    logic        e_last;
    logic [3:0]  e_cnt;
    logic [31:0] e_sum;
    logic        e_sv;
    logic        e_ovf;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t mk(logic sv, logic [31:0] d, logic rdy, logic clr, logic vld,
                              logic [31:0] data, logic last, logic [3:0] cnt,
                              logic [31:0] sum, logic svp, logic ovf);
    vec_t v;
    v.sv = sv; v.d = d; v.rdy = rdy; v.clr = clr;
    v.e_vld = vld; v.e_data = data; v.e_last = last; v.e_cnt = cnt;
    v.e_sum = sum; v.e_sv = svp; v.e_ovf = ovf;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic vld, logic [31:0] data, logic last, logic [3:0] cnt,
                         logic [31:0] sum, logic svp, logic ovf);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(vld));
    chk({tag, ".out_data"}, out_data, data);
    chk({tag, ".out_last"}, 32'(out_last), 32'(last));
    chk({tag, ".fifo_count"}, 32'(fifo_count), 32'(cnt));
    chk({tag, ".frame_sum"}, frame_sum, sum);
    chk({tag, ".frame_sum_valid"}, 32'(frame_sum_valid), 32'(svp));
    chk({tag, ".overflow"}, 32'(overflow), 32'(ovf));
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
  task automatic step(logic sv, logic [31:0] d, logic rdy, logic clr);
    @(negedge clk);
    seg_valid = sv; segment_combine = d; out_ready = rdy; clear_overflow = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = mk(1, 32'h1, 0, 0,        1, 32'h1, 0, 1, 32'h0, 0, 0);
    tbl[1]  = mk(1, 32'h2, 0, 0,        1, 32'h1, 0, 2, 32'h0, 0, 0);
    tbl[2]  = mk(1, 32'h3, 0, 0,        1, 32'h1, 0, 3, 32'h0, 0, 0);
    tbl[3]  = mk(1, 32'h4, 0, 0,        1, 32'h1, 0, 4, 32'hA, 1, 0);
    tbl[4]  = mk(0, 32'h0, 0, 0,        1, 32'h1, 0, 4, 32'hA, 0, 0);
    tbl[5]  = mk(0, 32'h0, 1, 0,        1, 32'h2, 0, 3, 32'hA, 0, 0);
    tbl[6]  = mk(0, 32'h0, 1, 0,        1, 32'h3, 0, 2, 32'hA, 0, 0);
    tbl[7]  = mk(0, 32'h0, 1, 0,        1, 32'h4, 1, 1, 32'hA, 0, 0);
    tbl[8]  = mk(0, 32'h0, 1, 0,        0, 32'h0, 0, 0, 32'hA, 0, 0);
    tbl[9]  = mk(1, 32'hFFFFFFFF, 0, 0, 1, 32'hFFFFFFFF, 0, 1, 32'hA, 0, 0);
    tbl[10] = mk(1, 32'h2, 0, 0,        1, 32'hFFFFFFFF, 0, 2, 32'hA, 0, 0);
    tbl[11] = mk(1, 32'h0, 0, 0,        1, 32'hFFFFFFFF, 0, 3, 32'hA, 0, 0);
    tbl[12] = mk(1, 32'h0, 0, 0,        1, 32'hFFFFFFFF, 0, 4, 32'h1, 1, 0);
    tbl[13] = mk(0, 32'h0, 1, 0,        1, 32'h2, 0, 3, 32'h1, 0, 0);
    tbl[14] = mk(0, 32'h0, 1, 0,        1, 32'h0, 0, 2, 32'h1, 0, 0);
    tbl[15] = mk(0, 32'h0, 1, 0,        1, 32'h0, 1, 1, 32'h1, 0, 0);
    tbl[16] = mk(0, 32'h0, 1, 0,        0, 32'h0, 0, 0, 32'h1, 0, 0);
    tbl[17] = mk(1, 32'h10, 1, 0,       1, 32'h10, 0, 1, 32'h1, 0, 0);
    tbl[18] = mk(1, 32'h11, 1, 0,       1, 32'h11, 0, 1, 32'h1, 0, 0);
    tbl[19] = mk(1, 32'h12, 1, 0,       1, 32'h12, 0, 1, 32'h1, 0, 0);
    tbl[20] = mk(1, 32'h13, 1, 0,       1, 32'h13, 1, 1, 32'h46, 1, 0);
    tbl[21] = mk(0, 32'h0, 1, 0,        0, 32'h0, 0, 0, 32'h46, 0, 0);

    reset = 1'b1; seg_valid = 1'b0; segment_combine = '0; out_ready = 1'b0; clear_overflow = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset_state", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].sv, tbl[i].d, tbl[i].rdy, tbl[i].clr);
      chk_all($sformatf("vec%0d", i), tbl[i].e_vld, tbl[i].e_data, tbl[i].e_last,
              tbl[i].e_cnt, tbl[i].e_sum, tbl[i].e_sv, tbl[i].e_ovf);
    end

    // Fill to capacity and drop the ninth word.
    for (int i = 0; i < 9; i++) step(1, 32'h21 + 32'(i), 0, 0);
    chk_all("full_drop", 1, 32'h21, 0, 8, 32'h9A, 0, 1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d.data", i), out_data, 32'h21 + 32'(i));
      chk($sformatf("drain%0d.last", i), 32'(out_last), 32'((i % 4) == 3));
      step(0, 0, 1, 0);
    end
    chk("drain_empty.count", 32'(fifo_count), 32'h0);
    // Frame position must restart at 0 after the drop.
    for (int i = 0; i < 4; i++) begin
      step(1, 32'h30 + 32'(i), 1, 0);
      chk($sformatf("repos%0d.data", i), out_data, 32'h30 + 32'(i));
      chk($sformatf("repos%0d.last", i), 32'(out_last), 32'(i == 3));
    end
    chk("repos.frame_sum", frame_sum, 32'hC6);
    chk("repos.frame_sum_valid", 32'(frame_sum_valid), 32'h1);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    chk_all("clear_ovf", 0, 0, 0, 0, 32'hC6, 0, 0);

    // Write and pop together while full: pop happens, write is dropped.
    for (int i = 0; i < 8; i++) step(1, 32'h40 + 32'(i), 0, 0);
    chk("fill8.count", 32'(fifo_count), 32'h8);
    step(1, 32'h48, 1, 0);
    chk_all("full_wr_pop", 1, 32'h41, 0, 7, 32'h116, 0, 1);
    step(1, 32'h49, 0, 1);
    chk("clr_no_drop.overflow", 32'(overflow), 32'h0);
    chk("clr_no_drop.count", 32'(fifo_count), 32'h8);
    step(1, 32'h4A, 0, 1);
    chk("clr_with_drop.overflow", 32'(overflow), 32'h1);

    // Reset raised between edges must clear outputs without waiting for a clock.
    @(negedge clk);
    seg_valid = 1'b0; out_ready = 1'b0; clear_overflow = 1'b0;
    reset = 1'b1;
    #1;
    chk_all("async_reset_a", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    step(1, 32'h7, 0, 0);
    step(1, 32'h8, 0, 0);
    chk("midframe.count", 32'(fifo_count), 32'h2);
    @(negedge clk);
    seg_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk_all("async_reset_b", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step(1, 32'h5, 0, 0);
    chk_all("post_reset_frame", 1, 32'h5, 0, 4, 32'h14, 1, 0);
    step(0, 0, 0, 0);
    chk("post_reset_pulse_end", 32'(frame_sum_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
